osc_freq_tracker: RTL

Digital frequency-tracking controller for the low-frequency tracking loop. It sits directly downstream of the injection-locked `osc` and closes the loop back to its `ctrl[1:0]` input. It counts rising edges of a divided oscillator phase over a fixed window of the system clock and compares the count with a programmable target. It then steps `ctrl` up or down by one code per window and asserts `lock` once the frequency stays in band.

---
 rtl/osc_trk_pkg.sv | 20 ++
 rtl/osc_edge_sync.sv | 26 ++
 rtl/osc_freq_tracker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/osc_trk_pkg.sv
// Shared types and constants for the oscillator frequency-tracking loop.
package osc_trk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_UPDATE  = 2'd3
  } trk_state_t;

  localparam int unsigned CTRL_W   = 2;
  localparam logic [CTRL_W-1:0] CTRL_MAX = 2'b11;
  localparam int unsigned INBAND_W = 4;

  localparam int unsigned DEF_CNT_W      = 12;
  localparam int unsigned DEF_WIN_CYC    = 1024;
  localparam int unsigned DEF_SETTLE_CYC = 64;
  localparam int unsigned DEF_LOCK_N     = 4;

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous oscillator phase.
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Decoded purely from flops, so the pulse is glitch-free and exactly one cycle wide.
  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/osc_freq_tracker.sv
// Windowed edge-count frequency tracker that steps the oscillator ctrl code and reports lock.
module osc_freq_tracker
  import osc_trk_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned WIN_CYC    = DEF_WIN_CYC,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned LOCK_N     = DEF_LOCK_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              osc_in,
  input  logic [CNT_W-1:0]  target,
  input  logic [CNT_W-1:0]  tol,
  output logic [CTRL_W-1:0] ctrl,
  output logic              lock,
  output logic [CNT_W-1:0]  meas_cnt,
  output logic              meas_valid
);

  localparam int unsigned TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);

  trk_state_t          state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]    meas_cnt_q, meas_cnt_d;
  logic                meas_valid_q, meas_valid_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                lock_q, lock_d;
  logic [INBAND_W-1:0] inband_q, inband_d;
  logic                edge_p;
  logic [CNT_W:0]      lo_sum, hi_sum;
  logic                is_slow, is_fast;

  osc_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (osc_in),
    .edge_o  (edge_p)
  );

  // One extra bit keeps count+tol and target+tol from wrapping.
  assign lo_sum  = {1'b0, edge_cnt_q} + {1'b0, tol};
  assign hi_sum  = {1'b0, target} + {1'b0, tol};
  assign is_slow = lo_sum < {1'b0, target};
  assign is_fast = {1'b0, edge_cnt_q} > hi_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      edge_cnt_q   <= '0;
      meas_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      ctrl_q       <= '0;
      lock_q       <= 1'b0;
      inband_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_cnt_q   <= meas_cnt_d;
      meas_valid_q <= meas_valid_d;
      ctrl_q       <= ctrl_d;
      lock_q       <= lock_d;
      inband_q     <= inband_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    edge_cnt_d   = edge_cnt_q;
    meas_cnt_d   = meas_cnt_q;
    meas_valid_d = 1'b0;
    ctrl_d       = ctrl_q;
    lock_d       = lock_q;
    inband_d     = inband_q;

    if (!en) begin
      // Abort: ctrl and the last measurement survive, loop progress does not.
      state_d    = ST_IDLE;
      timer_d    = '0;
      edge_cnt_d = '0;
      lock_d     = 1'b0;
      inband_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end
        ST_SETTLE: begin
          if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
            state_d    = ST_MEASURE;
            timer_d    = '0;
            edge_cnt_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        ST_MEASURE: begin
          if (edge_p && (edge_cnt_q != {CNT_W{1'b1}})) edge_cnt_d = edge_cnt_q + CNT_W'(1);
          if (timer_q == TMR_W'(WIN_CYC - 1)) begin
            state_d = ST_UPDATE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        ST_UPDATE: begin
          meas_cnt_d   = edge_cnt_q;
          meas_valid_d = 1'b1;
          edge_cnt_d   = '0;
          timer_d      = '0;
          if (is_slow || is_fast) begin
            inband_d = '0;
            lock_d   = 1'b0;
            if (is_slow && (ctrl_q != CTRL_MAX)) ctrl_d = ctrl_q + CTRL_W'(1);
            if (is_fast && (ctrl_q != '0))       ctrl_d = ctrl_q - CTRL_W'(1);
          end else begin
            if (inband_q != {INBAND_W{1'b1}}) inband_d = inband_q + INBAND_W'(1);
            lock_d = lock_q | (inband_d == INBAND_W'(LOCK_N));
          end
          // A pinned rail leaves ctrl unchanged, so no settle is needed.
          state_d = (ctrl_d != ctrl_q) ? ST_SETTLE : ST_MEASURE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ctrl       = ctrl_q;
  assign lock       = lock_q;
  assign meas_cnt   = meas_cnt_q;
  assign meas_valid = meas_valid_q;

endmodule
